// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, 32-iteration restoring divider for div/mod,
// and data SRAM request issued on the ex-to-mem handshake.
module ex_stage (
    input  logic         clk,
    input  logic         reset,
    output logic         ex_allowin,
    input  logic         id_to_ex_valid,
    input  logic [139:0] id_to_ex_wire,
    input  logic         mem_allowin,
    output logic         ex_to_mem_valid,
    output logic [103:0] ex_to_mem_wire,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [38:0]  ex_rf_zip
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ID_W    = 140;
    localparam int unsigned CNT_W   = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_MOD  = 4'd13;
    localparam logic [3:0] OP_DIVU = 4'd14;
    localparam logic [3:0] OP_MODU = 4'd15;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    logic            ex_valid;
    logic [ID_W-1:0] id_ex_q;

    logic [3:0]      alu_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] rkd_value;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] pc;
    logic            res_from_mem;
    logic            mem_we;

    logic [XLEN-1:0] alu_result;
    logic            ex_ready_go;
    logic            is_div;
    logic            div_signed;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  div_quo;
    logic [XLEN-1:0]  div_rem;
    logic [XLEN-1:0]  div_dsr;
    logic             dividend_neg;
    logic             divisor_neg;
    logic             div_zero;

    logic [XLEN:0]    div_trial;
    logic [XLEN:0]    div_diff;
    logic             q_bit;
    logic [XLEN-1:0]  rem_next;
    logic [XLEN-1:0]  abs_src1;
    logic [XLEN-1:0]  abs_src2;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;

    assign {alu_op, src1, src2, rkd_value, rf_we, rf_waddr, pc, res_from_mem, mem_we} = id_ex_q;

    assign is_div     = (alu_op[3:2] == 2'b11);
    assign div_signed = ~alu_op[1];

    // Pipeline handshake
    assign ex_ready_go     = ~is_div | (state == S_DONE);
    assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
    assign ex_to_mem_valid = ex_valid & ex_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
        end else if (ex_allowin) begin
            ex_valid <= id_to_ex_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q <= '0;
        end else if (id_to_ex_valid && ex_allowin) begin
            id_ex_q <= id_to_ex_wire;
        end
    end

    // Single-cycle ALU; div/mod results come from the sign-fixed divider outputs
    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:  alu_result = src1 + src2;
            OP_SUB:  alu_result = src1 - src2;
            OP_SLT:  alu_result = {31'd0, ($signed(src1) < $signed(src2))};
            OP_SLTU: alu_result = {31'd0, (src1 < src2)};
            OP_AND:  alu_result = src1 & src2;
            OP_OR:   alu_result = src1 | src2;
            OP_NOR:  alu_result = ~(src1 | src2);
            OP_XOR:  alu_result = src1 ^ src2;
            OP_SLL:  alu_result = src1 << src2[4:0];
            OP_SRL:  alu_result = src1 >> src2[4:0];
            OP_SRA:  alu_result = XLEN'($signed(src1) >>> src2[4:0]);
            OP_LUI:  alu_result = src2;
            OP_DIV,
            OP_DIVU: alu_result = quo_fix;
            OP_MOD,
            OP_MODU: alu_result = rem_fix;
            default: alu_result = '0;
        endcase
    end

    assign abs_src1 = (div_signed && src1[XLEN-1]) ? (~src1 + 32'd1) : src1;
    assign abs_src2 = (div_signed && src2[XLEN-1]) ? (~src2 + 32'd1) : src2;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign div_trial = {div_rem, div_quo[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, div_dsr};
    assign q_bit     = ~div_diff[XLEN];
    assign rem_next  = q_bit ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];

    // A zero divisor leaves quotient all-ones and remainder equal to |src1|
    assign quo_fix = (~div_zero && (dividend_neg ^ divisor_neg)) ? (~div_quo + 32'd1) : div_quo;
    assign rem_fix = dividend_neg ? (~div_rem + 32'd1) : div_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (ex_valid && is_div)        state_nx = S_BUSY;
            S_BUSY: if (count == CNT_LAST)         state_nx = S_DONE;
            S_DONE: if (ex_valid && mem_allowin)   state_nx = S_IDLE;
            default:                               state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            div_quo      <= '0;
            div_rem      <= '0;
            div_dsr      <= '0;
            dividend_neg <= 1'b0;
            divisor_neg  <= 1'b0;
            div_zero     <= 1'b0;
        end else if (state == S_IDLE && ex_valid && is_div) begin
            count        <= '0;
            div_quo      <= abs_src1;
            div_rem      <= '0;
            div_dsr      <= abs_src2;
            dividend_neg <= div_signed & src1[XLEN-1];
            divisor_neg  <= div_signed & src2[XLEN-1];
            div_zero     <= (src2 == '0);
        end else if (state == S_BUSY) begin
            count   <= count + 5'd1;
            div_rem <= rem_next;
            div_quo <= {div_quo[XLEN-2:0], q_bit};
        end
    end

    // Memory request fires only in the handshake cycle
    assign data_sram_en    = ex_valid & ex_ready_go & mem_allowin & (res_from_mem | mem_we);
    assign data_sram_we    = {4{data_sram_en & mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

    assign ex_to_mem_wire = {rf_we, rf_waddr, pc, alu_result, rkd_value, res_from_mem, mem_we};
    assign ex_rf_zip      = {res_from_mem & ex_valid, rf_we & ex_valid, rf_waddr, alu_result};

endmodule
